lifo_reverse_ctrl: RTL and testbench
====================================

Name: lifo_reverse_ctrl

Overview:
- Stream-side controller for the team's 8x8 push/pop stack (`lifo`).
- Accepts a valid/ready input stream and pushes each word into the stack.
- When the segment ends, it drives pops and presents the words on a valid/ready output stream in reverse order.
- Sits between a producer and a consumer; instantiated beside one `lifo`, with `lifo_dout` fed directly through as `m_data`.

Parameters:
- WIDTH, 8: data width; must equal the attached stack's WIDTH.
- DEPTH, 8: stack capacity in words; must equal the attached stack's DEPTH.
- CNT_W, 4: occupancy counter width; must be able to hold DEPTH.

Ports:
- clk  in  1  rising-edge clock, shared with the stack.
- rst  in  1  synchronous reset, active-high. The integrator ties the stack's rstn to !rst.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word accepted when s_valid && s_ready.
- s_data  in  WIDTH  input word.
- s_last  in  1  marks the final word of an input segment.
- m_valid  out  1  output word valid.
- m_ready  in  1  consumer ready.
- m_data  out  WIDTH  output word; combinational pass-through of lifo_dout.
- m_last  out  1  marks the final word of the reversed segment.
- lifo_push  out  1  push strobe to the stack.
- lifo_pop  out  1  pop strobe to the stack.
- lifo_din  out  WIDTH  push data; equals s_data.
- lifo_dout  in  WIDTH  stack output; registered and updated the cycle after a pop.
- lifo_full  in  1  stack full flag; used for checking only.
- lifo_empty  in  1  stack empty flag; used for checking only.
- busy  out  1  high whenever the FSM is in DRAIN.

Behaviour:
- Reset state, synchronous, active-high: FSM=FILL, cnt=0, last_seen=0, m_valid=0, m_last=0.
- Reset outputs: s_ready=1, lifo_push=0, lifo_pop=0, busy=0.
- A reset mid-segment discards all data; the stack is reset in the same cycle via the tie-off.
- lifo_push and lifo_pop are never high in the same cycle. The stack prioritises push, so a simultaneous pop would be lost.
- FILL state:
  - s_ready = (cnt < DEPTH).
  - On an s_valid && s_ready handshake: lifo_push=1 (combinational, same cycle); cnt increments at the next edge.
  - Leave for DRAIN at that edge if the accepted word has s_last=1 (last_seen<=1) or cnt+1 == DEPTH (last_seen<=0).
  - lifo_pop=0 throughout FILL.
- DRAIN state:
  - s_ready=0 and busy=1.
  - Pop-enable condition: cnt > 0 && (!m_valid || m_ready).
  - When the pop-enable condition holds: lifo_pop=1 and cnt decrements at the next edge.
  - At the next edge m_valid <= 1; the popped word appears on lifo_dout, and hence m_data, in that same next cycle.
  - m_last <= (cnt == 1 && last_seen) on each pop.
  - If m_valid && m_ready and no pop is issued: m_valid <= 0 and m_last <= 0.
  - Once cnt == 0 and the final word has completed its handshake: FSM <= FILL, last_seen <= 0.
- Latency and throughput:
  - The first output word is valid 2 cycles after the segment-ending input handshake: that edge enters DRAIN, the next cycle pops, the following cycle has m_valid.
  - Steady state is 1 word/cycle with m_ready held high.
- Backpressure: while m_valid && !m_ready, no pop is issued. m_data holds, because the stack dout is stable when it is neither pushed nor popped.
- Segment rules:
  - A 1-word segment (s_last on the first word) outputs 1 word with m_last=1.
  - A segment that fills the stack without s_last is drained reversed with m_last=0 on every word. The following words form a new segment.
- Assertions for the bench:
  - Never push while lifo_full.
  - Never pop while lifo_empty.
  - cnt mirrors stack occupancy: lifo_empty == (cnt==0) and lifo_full == (cnt==DEPTH).

Test Plan:
- Reset: hold rst 2 cycles, then release -> s_ready=1, m_valid=0, busy=0, lifo_empty=1.
- Basic reverse: send 0x11,0x22,0x33 (s_last on 0x33) with m_ready=1 -> m_data 0x33,0x22,0x11 on consecutive cycles. m_valid rises 2 cycles after the 0x33 handshake; m_last=1 only on 0x11; then s_ready returns to 1.
- Full without last: send 0x01..0x08 with s_last=0 -> s_ready drops after 0x08; output is 0x08..0x01 with m_last=0 throughout; lifo_full is never violated.
- Backpressure: 4-word segment 0xA0..0xA3 with m_ready low for 3 cycles after the first m_valid -> m_data holds 0xA3 stable, lifo_pop stays 0, and the order continues 0xA2,0xA1,0xA0.
- Single word plus back-to-back: segment {0x5A, last}, then immediately {0xC3,0x3C, last} -> outputs 0x5A(last), 0x3C, 0xC3(last); the second segment is not accepted until busy=0.
- Mid-drain reset: assert rst while 2 words remain -> next cycle m_valid=0, s_ready=1, busy=0; a new segment 0x77(last) outputs exactly 0x77 with m_last=1.

Source files
------------

// File: rtl/lifo_reverse_ctrl.sv
// lifo_reverse_ctrl: buffers a valid/ready segment into an attached stack and replays it reversed.
module lifo_reverse_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             lifo_push,
    output logic             lifo_pop,
    output logic [WIDTH-1:0] lifo_din,
    input  logic [WIDTH-1:0] lifo_dout,
    input  logic             lifo_full,
    input  logic             lifo_empty,
    output logic             busy
);
    typedef enum logic {FILL, DRAIN} state_t;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             last_seen;
    logic             accept;
    logic             pop_en;
    assign s_ready   = (state == FILL) && (cnt < CNT_W'(DEPTH));
    assign accept    = s_valid && s_ready;
    // a pop refills the output register only when it is empty or being consumed
    assign pop_en    = (state == DRAIN) && (cnt != '0) && (!m_valid || m_ready);
    assign lifo_push = accept;
    assign lifo_pop  = pop_en;
    assign lifo_din  = s_data;
    assign m_data    = lifo_dout;
    assign busy      = (state == DRAIN);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            cnt       <= '0;
            last_seen <= 1'b0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
        end else if (state == FILL) begin
            if (accept) begin
                cnt <= cnt + CNT_W'(1);
                if (s_last || cnt == CNT_W'(DEPTH - 1)) begin
                    state     <= DRAIN;
                    last_seen <= s_last;
                end
            end
        end else begin
            if (pop_en) begin
                cnt     <= cnt - CNT_W'(1);
                m_valid <= 1'b1;
                m_last  <= (cnt == CNT_W'(1)) && last_seen;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end
            if (cnt == '0 && (!m_valid || m_ready)) begin
                state     <= FILL;
                last_seen <= 1'b0;
            end
        end
    end
    assert property (@(posedge clk) disable iff (rst)
        !(lifo_push && lifo_full) && !(lifo_pop && lifo_empty) && !(lifo_push && lifo_pop)
        && (lifo_empty == (cnt == '0)) && (lifo_full == (cnt == CNT_W'(DEPTH))));
endmodule

// File: tb/tb_lifo_reverse_ctrl.sv
// tb_lifo_reverse_ctrl: directed checks of the reversing controller beside a behavioural 8x8 stack.
module tb_lifo_reverse_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       s_valid, s_ready, s_last;
    logic [7:0] s_data;
    logic       m_valid, m_ready, m_last;
    logic [7:0] m_data;
    logic       lifo_push, lifo_pop, lifo_full, lifo_empty, busy;
    logic [7:0] lifo_din, lifo_dout;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] got_d[$];
    logic       got_l[$];

    always #5 clk = ~clk;

    lifo_reverse_ctrl #(.WIDTH(8), .DEPTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .lifo_push(lifo_push), .lifo_pop(lifo_pop), .lifo_din(lifo_din),
        .lifo_dout(lifo_dout), .lifo_full(lifo_full), .lifo_empty(lifo_empty),
        .busy(busy)
    );

    // behavioural stack: push has priority, dout registered and updated only on pop
    logic [7:0] mem [8];
    logic [3:0] sp;
    logic       rstn;
    assign rstn       = !rst;
    assign lifo_full  = (sp == 4'd8);
    assign lifo_empty = (sp == 4'd0);
    always_ff @(posedge clk) begin
        if (!rstn) begin
            sp        <= '0;
            lifo_dout <= '0;
        end else if (lifo_push) begin
            mem[sp[2:0]] <= lifo_din;
            sp           <= sp + 4'd1;
        end else if (lifo_pop) begin
            lifo_dout <= mem[sp[2:0] - 3'd1];
            sp        <= sp - 4'd1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk)
        if (!rst && m_valid && m_ready) begin
            got_d.push_back(m_data);
            got_l.push_back(m_last);
        end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("push_while_full", 32'(lifo_push && lifo_full), 0);
            chk("pop_while_empty", 32'(lifo_pop && lifo_empty), 0);
            chk("push_and_pop", 32'(lifo_push && lifo_pop), 0);
        end
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("send_timeout", 0, 1);
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || m_valid) && n < 100);
        if (n >= 100) chk("idle_timeout", 0, 1);
    endtask

    // d holds word i at byte i, l holds its last flag at bit i
    task automatic expect_out(input string tag, input logic [63:0] d, input logic [7:0] l, input int n);
        chk({tag, "_count"}, 32'(got_d.size()), 32'(n));
        for (int i = 0; i < n && i < got_d.size(); i++) begin
            chk({tag, "_data"}, 32'(got_d[i]), 32'(d[8*i +: 8]));
            chk({tag, "_last"}, 32'(got_l[i]), 32'(l[i]));
        end
        got_d.delete();
        got_l.delete();
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_s_ready", 32'(s_ready), 1);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_empty", 32'(lifo_empty), 1);
        chk("rst_push", 32'(lifo_push), 0);
        chk("rst_pop", 32'(lifo_pop), 0);

        send(8'h11, 0); send(8'h22, 0); send(8'h33, 1);
        #1;
        chk("rev_busy", 32'(busy), 1);
        chk("rev_mv_early", 32'(m_valid), 0);
        chk("rev_pop", 32'(lifo_pop), 1);
        @(negedge clk); #1;
        chk("rev_mv", 32'(m_valid), 1);
        chk("rev_d0", 32'(m_data), 32'h33);
        chk("rev_l0", 32'(m_last), 0);
        @(negedge clk); #1;
        chk("rev_d1", 32'(m_data), 32'h22);
        chk("rev_l1", 32'(m_last), 0);
        @(negedge clk); #1;
        chk("rev_d2", 32'(m_data), 32'h11);
        chk("rev_l2", 32'(m_last), 1);
        @(negedge clk); #1;
        chk("rev_done_mv", 32'(m_valid), 0);
        chk("rev_done_ready", 32'(s_ready), 1);
        chk("rev_done_busy", 32'(busy), 0);
        expect_out("rev", 64'h112233, 8'b100, 3);

        for (int i = 1; i <= 8; i++) send(8'(i), 0);
        #1;
        chk("full_s_ready", 32'(s_ready), 0);
        chk("full_flag", 32'(lifo_full), 1);
        wait_idle();
        expect_out("full", 64'h0102030405060708, 8'h00, 8);

        m_ready = 1'b0;
        send(8'hA0, 0); send(8'hA1, 0); send(8'hA2, 0); send(8'hA3, 1);
        @(negedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            chk("bp_mv", 32'(m_valid), 1);
            chk("bp_hold", 32'(m_data), 32'hA3);
            chk("bp_no_pop", 32'(lifo_pop), 0);
            @(negedge clk); #1;
        end
        m_ready = 1'b1;
        wait_idle();
        expect_out("bp", 64'hA0A1A2A3, 8'b1000, 4);

        send(8'h5A, 1);
        #1;
        chk("b2b_s_ready", 32'(s_ready), 0);
        chk("b2b_busy", 32'(busy), 1);
        send(8'hC3, 0); send(8'h3C, 1);
        wait_idle();
        expect_out("b2b", 64'hC33C5A, 8'b101, 3);

        m_ready = 1'b0;
        send(8'h10, 0); send(8'h11, 0); send(8'h12, 0); send(8'h13, 1);
        @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mid_rst_mv", 32'(m_valid), 0);
        chk("mid_rst_ready", 32'(s_ready), 1);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_empty", 32'(lifo_empty), 1);
        got_d.delete();
        got_l.delete();
        m_ready = 1'b1;
        send(8'h77, 1);
        wait_idle();
        expect_out("post_rst", 64'h77, 8'b1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
